// File: rtl/boot_pkg.sv
// Shared types and constants for the boot image streamer.
// Holds the FSM state encoding, the error codes reported on err_code
// and the default image length.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_FETCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_TX  = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ECHO    = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int DEFAULT_IMAGE_LEN = 32'd1024;

endpackage

// File: rtl/uart_rx_hold.sv
// One-byte holding register between the UART receiver and the streamer FSM.
// A received byte stays pending until the FSM consumes it; a new byte
// arriving while one is still pending (and not being consumed in the same
// cycle) is flagged as an overrun.
module uart_rx_hold (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       consume,
    input  logic       clear,
    output logic [7:0] hold_data,
    output logic       pending,
    output logic       overrun
);

    logic [7:0] hold_data_r;
    logic       pending_r;

    // Capture incoming bytes and track whether one is waiting to be consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_r <= 8'd0;
            pending_r   <= 1'b0;
        end else if (clear) begin
            pending_r   <= 1'b0;
        end else if (rx_done) begin
            hold_data_r <= rx_data;
            pending_r   <= 1'b1;
        end else if (consume) begin
            pending_r   <= 1'b0;
        end else begin
            pending_r   <= pending_r;
        end
    end

    assign hold_data = hold_data_r;
    assign pending   = pending_r;
    // A byte consumed in the same cycle frees the slot, so that is not an overrun.
    assign overrun   = rx_done & pending_r & ~consume;

endmodule

// File: rtl/boot_image_streamer.sv
// Host-side responder for the UART bootloader protocol. Every received byte
// requests the next image byte; all but the first are also the echo of the
// previously transmitted byte and are compared against it.
// Optional feature: define BOOT_STREAMER_TIMEOUT_EN to abort a session when
// no request arrives within TIMEOUT_CYCLES cycles in WAIT_REQ.
module boot_image_streamer
    import boot_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int IMAGE_LEN      = DEFAULT_IMAGE_LEN,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              transmit,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] byte_count
);

    // Completion is judged on a count one bit wider than the address so a
    // full 2^ADDR_W image is not confused with the wrapped address value.
    localparam logic [ADDR_W:0] IMAGE_LEN_C = (ADDR_W+1)'(IMAGE_LEN);

    state_e              state_r, state_s;
    logic                first_r, first_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                error_r, error_s;
    logic [1:0]          err_code_r, err_code_s;
    logic [ADDR_W-1:0]   byte_count_r, byte_count_s;
    logic [ADDR_W-1:0]   rom_addr_r, rom_addr_s;
    logic [ADDR_W:0]     sent_cnt_r, sent_cnt_s;
    logic [ADDR_W:0]     sent_cnt_inc_s;
    logic [7:0]          tx_data_r, tx_data_s;
    logic [7:0]          last_sent_r, last_sent_s;
    logic                transmit_r, transmit_s;
    logic                clear_s;
    logic                consume_s;
    logic                rx_done_g_s;
    logic [7:0]          hold_data_s;
    logic                pending_s;
    logic                overrun_s;

`ifdef BOOT_STREAMER_TIMEOUT_EN
    logic [31:0]         to_cnt_r, to_cnt_s;
`else
    logic                timeout_unused_s;
    assign timeout_unused_s = ^(32'(TIMEOUT_CYCLES));
`endif

    // Bytes are only accepted while a session is running; stray bytes are dropped.
    assign rx_done_g_s    = rx_done & busy_r;
    assign consume_s      = (state_r == ST_WAIT_REQ) & pending_s;
    assign sent_cnt_inc_s = sent_cnt_r + (ADDR_W+1)'(1);

    uart_rx_hold u_rx_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done_g_s),
        .consume   (consume_s),
        .clear     (clear_s),
        .hold_data (hold_data_s),
        .pending   (pending_s),
        .overrun   (overrun_s)
    );

    // Next-state and next-output computation for the session FSM.
    always_comb begin
        state_s      = state_r;
        first_s      = first_r;
        busy_s       = busy_r;
        done_s       = done_r;
        error_s      = error_r;
        err_code_s   = err_code_r;
        byte_count_s = byte_count_r;
        rom_addr_s   = rom_addr_r;
        sent_cnt_s   = sent_cnt_r;
        tx_data_s    = tx_data_r;
        last_sent_s  = last_sent_r;
        transmit_s   = 1'b0;
        clear_s      = 1'b0;
`ifdef BOOT_STREAMER_TIMEOUT_EN
        to_cnt_s     = 32'd0;
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_s       = 1'b0;
                    error_s      = 1'b0;
                    err_code_s   = ERR_NONE;
                    byte_count_s = '0;
                    rom_addr_s   = '0;
                    sent_cnt_s   = '0;
                    clear_s      = 1'b1;
                    first_s      = 1'b1;
                    busy_s       = 1'b1;
                    state_s      = ST_WAIT_REQ;
                end else begin
                    state_s      = state_r;
                end
            end
            ST_WAIT_REQ: begin
                if (pending_s) begin
                    if (!first_r && (hold_data_s != last_sent_r)) begin
                        state_s    = ST_ERROR;
                        error_s    = 1'b1;
                        err_code_s = ERR_ECHO;
                        busy_s     = 1'b0;
                    end else if (!first_r && (sent_cnt_inc_s == IMAGE_LEN_C)) begin
                        byte_count_s = byte_count_r + ADDR_W'(1);
                        rom_addr_s   = rom_addr_r + ADDR_W'(1);
                        sent_cnt_s   = sent_cnt_inc_s;
                        state_s      = ST_DONE;
                        done_s       = 1'b1;
                        busy_s       = 1'b0;
                    end else if (!first_r) begin
                        byte_count_s = byte_count_r + ADDR_W'(1);
                        rom_addr_s   = rom_addr_r + ADDR_W'(1);
                        sent_cnt_s   = sent_cnt_inc_s;
                        first_s      = 1'b0;
                        state_s      = ST_FETCH;
                    end else begin
                        first_s      = 1'b0;
                        state_s      = ST_FETCH;
                    end
`ifdef BOOT_STREAMER_TIMEOUT_EN
                end else if (to_cnt_r == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_s    = ST_ERROR;
                    error_s    = 1'b1;
                    err_code_s = ERR_TIMEOUT;
                    busy_s     = 1'b0;
                end else begin
                    to_cnt_s   = to_cnt_r + 32'd1;
                end
`else
                end else begin
                    state_s    = state_r;
                end
`endif
            end
            ST_FETCH: begin
                if (overrun_s) begin
                    state_s    = ST_ERROR;
                    error_s    = 1'b1;
                    err_code_s = ERR_OVERRUN;
                    busy_s     = 1'b0;
                end else begin
                    state_s    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (overrun_s) begin
                    state_s    = ST_ERROR;
                    error_s    = 1'b1;
                    err_code_s = ERR_OVERRUN;
                    busy_s     = 1'b0;
                end else begin
                    tx_data_s   = rom_data;
                    last_sent_s = rom_data;
                    transmit_s  = 1'b1;
                    state_s     = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (overrun_s) begin
                    state_s    = ST_ERROR;
                    error_s    = 1'b1;
                    err_code_s = ERR_OVERRUN;
                    busy_s     = 1'b0;
                end else if (tx_done) begin
                    state_s    = ST_WAIT_REQ;
                end else begin
                    state_s    = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; outputs are all driven straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            first_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            err_code_r   <= ERR_NONE;
            byte_count_r <= '0;
            rom_addr_r   <= '0;
            sent_cnt_r   <= '0;
            tx_data_r    <= 8'd0;
            last_sent_r  <= 8'd0;
            transmit_r   <= 1'b0;
`ifdef BOOT_STREAMER_TIMEOUT_EN
            to_cnt_r     <= 32'd0;
`endif
        end else begin
            state_r      <= state_s;
            first_r      <= first_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
            err_code_r   <= err_code_s;
            byte_count_r <= byte_count_s;
            rom_addr_r   <= rom_addr_s;
            sent_cnt_r   <= sent_cnt_s;
            tx_data_r    <= tx_data_s;
            last_sent_r  <= last_sent_s;
            transmit_r   <= transmit_s;
`ifdef BOOT_STREAMER_TIMEOUT_EN
            to_cnt_r     <= to_cnt_s;
`endif
        end
    end

    assign tx_data    = tx_data_r;
    assign transmit   = transmit_r;
    assign rom_addr   = rom_addr_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign err_code   = err_code_r;
    assign byte_count = byte_count_r;

endmodule

// File: tb/tb_boot_image_streamer.sv
// Bench for boot_image_streamer: emulates the bootloader side of the link
// and a synchronous image ROM. Expected transmit bytes are queued when a
// request is sent and checked by an independent monitor on transmit pulses.
module tb_boot_image_streamer;

    localparam int AW  = 2;
    localparam int LEN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_done = 1'b0;
    logic          tx_done = 1'b0;
    logic [7:0]    tx_data;
    logic          transmit;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] byte_count;

    logic [7:0]    rom_mem [LEN];
    logic [7:0]    exp_q [$];
    int            tests = 0;
    int            fails = 0;
    int            tx_pulses = 0;
    logic          prev_tx = 1'b0;
    logic [7:0]    exp_b;

    boot_image_streamer #(.ADDR_W(AW), .IMAGE_LEN(LEN), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .transmit(transmit), .tx_done(tx_done), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Synchronous image ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every transmit pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && transmit) begin
            tx_pulses++;
            chk("tx_single_cycle", {31'd0, prev_tx}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_transmit: got byte %0h with nothing expected", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_b});
            end
        end
        prev_tx = rst_n && transmit;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data = d; rx_done = 1'b1; cyc(1); rx_done = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1; cyc(1); tx_done = 1'b0;
    endtask

    task automatic pulse_both(input logic [7:0] d);
        rx_data = d; rx_done = 1'b1; tx_done = 1'b1; cyc(1);
        rx_done = 1'b0; tx_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(1); start = 1'b0; tx_pulses = 0;
    endtask

    task automatic wait_transmit(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'd0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (transmit) begin ok = 1'b1; b = tx_data; end
            else cyc(1);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL transmit_wait: no transmit within 40 cycles, queue depth %0d", exp_q.size());
        end
    endtask

    // Bootloader emulation: request, then echo each received byte, up to nbytes
    // bytes; byte index 'mis' is echoed corrupted (session stops there).
    task automatic stream(input int mis, input int nbytes);
        logic [7:0] b, echo;
        bit ok;
        int mode;
        exp_q.push_back(rom_mem[0]);
        pulse_rx(8'($urandom));
        for (int k = 0; k < nbytes; k++) begin
            wait_transmit(b, ok);
            if (!ok) return;
            cyc($urandom_range(1, 3));
            echo = (k == mis) ? (b ^ 8'($urandom_range(1, 255))) : b;
            if (echo == b && k + 1 < LEN) exp_q.push_back(rom_mem[k+1]);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                pulse_tx(); cyc($urandom_range(0, 2)); pulse_rx(echo);
            end else if (mode == 1) begin
                pulse_both(echo);
            end else begin
                pulse_rx(echo); cyc($urandom_range(0, 2)); pulse_tx();
            end
            if (k == mis) return;
        end
    endtask

    task automatic check_end(input string tag, input logic d, input logic e, input logic [1:0] code,
                             input int bc, input int addr, input logic bsy);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
        chk({tag, "_err_code"}, {30'd0, err_code}, {30'd0, code});
        chk({tag, "_byte_count"}, {30'd0, byte_count}, 32'(bc % (1 << AW)));
        chk({tag, "_rom_addr"}, {30'd0, rom_addr}, 32'(addr % (1 << AW)));
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, bsy});
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_rom();
        for (int i = 0; i < LEN; i++) rom_mem[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        int mis;
        rom_mem[0] = 8'hA5; rom_mem[1] = 8'h3C; rom_mem[2] = 8'h00; rom_mem[3] = 8'hFF;
        cyc(2);
        check_end("reset", 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
        chk("reset_transmit", {31'd0, transmit}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Stray byte while idle must be dropped.
        pulse_rx(8'h55);
        cyc(3);
        chk("idle_stray_busy", {31'd0, busy}, 32'd0);

        // Normal stream of the fixed image; full-length image also wraps rom_addr.
        do_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        stream(-1, LEN);
        cyc(5);
        check_end("normal", 1'b1, 1'b0, 2'd0, LEN, LEN, 1'b0);
        chk("normal_tx_pulses", 32'(tx_pulses), 32'(LEN));

        // Echo mismatch on the second request.
        do_start();
        stream(0, LEN);
        cyc(10);
        check_end("mismatch", 1'b0, 1'b1, 2'd1, 0, 0, 1'b0);

        // Randomized sessions: random image, random corrupt position or none.
        for (int s = 0; s < 6; s++) begin
            random_rom();
            mis = $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(0, LEN - 1));
            do_start();
            stream(mis, LEN);
            cyc(10);
            if (mis < 0) check_end("rand_ok", 1'b1, 1'b0, 2'd0, LEN, LEN, 1'b0);
            else         check_end("rand_mis", 1'b0, 1'b1, 2'd1, mis, mis, 1'b0);
        end

        // Overrun: two bytes 3 cycles apart while waiting for tx completion.
        random_rom();
        do_start();
        exp_q.push_back(rom_mem[0]);
        pulse_rx(8'h00);
        wait_transmit(b, ok);
        cyc(1);
        pulse_rx(b);
        cyc(2);
        pulse_rx(b);
        cyc(3);
        pulse_tx();
        cyc(8);
        check_end("overrun", 1'b0, 1'b1, 2'd2, 0, 0, 1'b0);

        // Async reset during WAIT_TX after two bytes, then a clean restart.
        rom_mem[0] = 8'hA5; rom_mem[1] = 8'h3C; rom_mem[2] = 8'h00; rom_mem[3] = 8'hFF;
        do_start();
        stream(-1, 2);
        wait_transmit(b, ok);
        chk("pre_reset_rom_addr", {30'd0, rom_addr}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_transmit", {31'd0, transmit}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        exp_q.delete();
        check_end("rst", 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        do_start();
        stream(-1, LEN);
        cyc(5);
        check_end("after_reset", 1'b1, 1'b0, 2'd0, LEN, LEN, 1'b0);

        // Stray byte after DONE, then restart: no stale request may fire.
        pulse_rx(8'h77);
        cyc(3);
        do_start();
        cyc(10);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_no_tx", 32'(tx_pulses), 32'd0);
        stream(-1, LEN);
        cyc(5);
        check_end("restart", 1'b1, 1'b0, 2'd0, LEN, LEN, 1'b0);

        // Request-wait limit.
        do_start();
`ifdef BOOT_STREAMER_TIMEOUT_EN
        cyc(60);
        check_end("timeout", 1'b0, 1'b1, 2'd3, 0, 0, 1'b0);
`else
        cyc(1000);
        check_end("no_timeout", 1'b0, 1'b0, 2'd0, 0, 0, 1'b1);
`endif
        rst_n = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/boot_image_streamer.md
Name: boot_image_streamer

Overview:
- Host-side responder to the UART bootloader protocol: streams an image from a synchronous ROM one byte per request and checks each echoed byte.
- Protocol: every byte the bootloader sends is a request for the next byte. The first byte is a pure request (content ignored); each later byte is also the echo of the previous byte sent.
- Sits between a UART rx/tx pair and an image ROM, in the test host or a loader FPGA.

Parameters:
- ADDR_W, 16, ROM address and byte-count width.
- IMAGE_LEN, 1024, bytes to stream; legal range 1..2^ADDR_W.
- TIMEOUT_CYCLES, 1000000, request-wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a session.
- rx_data  in  8  received byte; valid when rx_done is high.
- rx_done  in  1  one-cycle pulse per received byte.
- tx_data  out  8  byte to transmit; held stable from the transmit pulse until tx_done.
- transmit  out  1  one-cycle pulse; starts a UART transmission.
- tx_done  in  1  one-cycle pulse when the transmission completes.
- rom_addr  out  ADDR_W  ROM read address; rom_data is valid 1 cycle after.
- rom_data  in  8  ROM read data.
- busy  out  1  high during a session.
- done  out  1  sticky; all IMAGE_LEN bytes sent and echoes verified.
- error  out  1  sticky; session aborted.
- err_code  out  2  0 none, 1 echo mismatch, 2 rx overrun, 3 timeout.
- byte_count  out  ADDR_W  number of echoes verified this session.

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; rx holding register empty.
- Rx holding register:
  - Captures rx_data on rx_done and sets pending.
  - The FSM clears pending when it consumes the byte.
  - rx_done while pending is already set: overrun -> ERROR, err_code=2.
- FSM states: IDLE, WAIT_REQ, FETCH, SEND, WAIT_TX, DONE, ERROR.
- IDLE/DONE/ERROR on start:
  - Clear done, error, err_code, byte_count, rom_addr and pending.
  - Set first=1, busy=1; go to WAIT_REQ.
  - start at any other time is ignored.
- WAIT_REQ with pending: consume the byte.
  - If first=0 and rx_data != last_sent: ERROR, err_code=1.
  - If first=0 and the echo matches: byte_count+1, rom_addr+1.
  - After that update, byte_count==IMAGE_LEN -> DONE (done=1, busy=0, no transmit).
  - Otherwise go to FETCH and set first=0.
- FETCH: one cycle for the ROM read. Next cycle (SEND) latch rom_data into tx_data and last_sent, pulse transmit for exactly 1 cycle, go to WAIT_TX.
- WAIT_TX: on tx_done -> WAIT_REQ.
  - An rx byte arriving here is held in the holding register and consumed in WAIT_REQ.
  - tx_done and rx_done in the same cycle are both honoured.
- Latency: request consumed -> transmit pulse = 2 cycles.
- rom_addr/byte_count are ADDR_W-bit counters. With IMAGE_LEN=2^ADDR_W the final increment wraps rom_addr to 0; completion is detected from a separate ADDR_W+1-bit internal count, not from the wrapped value.
- ERROR/DONE: busy=0, no further transmits; rx bytes are discarded.
- A reset mid-transmission drops transmit immediately; the UART's partial frame is not this block's concern.
- Stray rx while IDLE/DONE/ERROR: ignored and not latched.

Optional Feature:
- Macro: BOOT_STREAMER_TIMEOUT_EN.
- With the macro: a 32-bit counter runs while in WAIT_REQ and clears on entry to WAIT_REQ. Reaching TIMEOUT_CYCLES without a consumed byte -> ERROR, err_code=3.
- Without the macro: no counter; WAIT_REQ waits indefinitely; err_code 3 never occurs.

Decomposition:
- Shared package boot_pkg:
  - FSM state enum.
  - err_code constants: ERR_NONE, ERR_ECHO, ERR_OVERRUN, ERR_TIMEOUT.
  - Default IMAGE_LEN.
- Sub-module uart_rx_hold: one-byte holding register with pending/consume/overrun. Ports: clk, rst_n, rx_data, rx_done, consume, clear -> hold_data, pending, overrun.

Test Plan:
- Normal stream: IMAGE_LEN=4, ROM={A5,3C,00,FF}; send request 00, then echo each sent byte -> tx sequence A5,3C,00,FF; done=1, byte_count=4, error=0; exactly 4 transmit pulses.
- Echo mismatch: on 2nd request send 3C instead of A5 -> error=1, err_code=1, byte_count=0, no further transmit.
- Overrun: two rx_done pulses 3 cycles apart while in WAIT_TX -> error=1, err_code=2.
- Async reset mid-stream: assert rst_n=0 during WAIT_TX after 2 bytes -> all outputs 0 immediately; a new start restarts from rom_addr 0 with first byte A5.
- Restart and wrap: ADDR_W=2, IMAGE_LEN=4, full session -> done=1, rom_addr=0. Second start then streams the same image again with no stale pending byte.
- Timeout (macro on, TIMEOUT_CYCLES=50): no request for 50 cycles after start -> error=1, err_code=3. With the macro off, still busy after 1000 cycles.
